// File: rtl/hit_sched.sv
// hit_sched: collects hit-complete pulses from NCH channels and serves them round-robin on one event port.
// Latency: hit_done in cycle N -> pending at N+1 -> ev_vld at N+2; at most one event every 2 cycles.
// Backpressure: ev_vld holds the event until ev_rdy; a capture into an occupied slot is counted as a drop.
// Optional feature macro: HIT_SCHED_TS_EN (per-channel capture timestamps on ev_ts).
module hit_sched #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic [NCH-1:0]    hit_done,
   input  logic [16*NCH-1:0] hit_id,
   input  logic [NCH-1:0]    cfg_ch_en,
   input  logic              cfg_ts_clr,
   output logic              ev_vld,
   input  logic              ev_rdy,
   output logic [CHW-1:0]    ev_ch,
   output logic [15:0]       ev_id,
   output logic [31:0]       ev_ts,
   output logic [NCH-1:0]    stu_pend,
   output logic [15:0]       stu_drop,
   output logic [15:0]       stu_ev_cnt
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESENT = 2'd1;

   logic [1:0]     state;
   logic [CHW-1:0] rr_ptr;
   logic [NCH-1:0] pend;
   logic [15:0]    id_q [NCH];
   logic [NCH-1:0] cap;
   logic [NCH-1:0] load;
   logic [NCH-1:0] drop;
   logic           sel_vld;
   logic [CHW-1:0] sel_ch;
   logic [16:0]    drop_sum;

   // Channel index base+k, wrapped into 0..NCH-1 (NCH need not be a power of two).
   function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NCH) s = s - NCH;
      return s[CHW-1:0];
   endfunction

   // Round-robin pick: first pending slot at or after rr_ptr.
   always_comb begin
      sel_vld = 1'b0;
      sel_ch  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!sel_vld && pend[rr_idx(rr_ptr, k)]) begin
            sel_vld = 1'b1;
            sel_ch  = rr_idx(rr_ptr, k);
         end
      end
   end

   // Per-channel capture/load/drop qualifiers and the saturating drop total.
   always_comb begin
      cap  = hit_done & cfg_ch_en;
      load = '0;
      if (state == S_IDLE && sel_vld) load[sel_ch] = 1'b1;
      // A slot being handed to the FSM this cycle frees up, so a coincident capture refills it instead of dropping.
      drop     = cap & pend & ~load;
      drop_sum = {1'b0, stu_drop};
      for (int i = 0; i < NCH; i++) drop_sum = drop_sum + {16'd0, drop[i]};
      if (drop_sum > 17'h0FFFF) drop_sum = 17'h0FFFF;
   end

   // Pending slots: fill on capture, refill on same-cycle load, clear when handed to the FSM.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         pend <= '0;
         for (int i = 0; i < NCH; i++) id_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cap[i]) begin
               if (!pend[i] || load[i]) id_q[i] <= hit_id[16*i +: 16];
               pend[i] <= 1'b1;
            end else if (load[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   // Event presenter FSM: load one slot, hold it until accepted.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         ev_vld     <= 1'b0;
         ev_ch      <= '0;
         ev_id      <= '0;
         stu_ev_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_vld) begin
                  ev_ch  <= sel_ch;
                  ev_id  <= id_q[sel_ch];
                  rr_ptr <= rr_idx(sel_ch, 1);
                  ev_vld <= 1'b1;
                  state  <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (ev_rdy) begin
                  ev_vld     <= 1'b0;
                  stu_ev_cnt <= stu_ev_cnt + 16'd1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               ev_vld <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating dropped-event counter.
   always_ff @(posedge clk_sys) begin
      if (rst) stu_drop <= '0;
      else     stu_drop <= drop_sum[15:0];
   end

   assign stu_pend = pend;

`ifdef HIT_SCHED_TS_EN
   logic [31:0] ts_cnt;
   logic [31:0] ts_q [NCH];
   logic [31:0] ev_ts_q;

   // Free-running timestamp; a clear takes effect the following cycle.
   always_ff @(posedge clk_sys) begin
      if (rst)             ts_cnt <= '0;
      else if (cfg_ts_clr) ts_cnt <= '0;
      else                 ts_cnt <= ts_cnt + 32'd1;
   end

   // Timestamp shadow of the slot data, plus the presented timestamp.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) ts_q[i] <= '0;
         ev_ts_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cap[i] && (!pend[i] || load[i])) ts_q[i] <= ts_cnt;
         end
         if (state == S_IDLE && sel_vld) ev_ts_q <= ts_q[sel_ch];
      end
   end

   assign ev_ts = ev_ts_q;
`else
   logic unused_ts_clr;
   assign unused_ts_clr = cfg_ts_clr;
   assign ev_ts = 32'h0;
`endif

endmodule

// File: tb/tb_hit_sched.sv
// tb_hit_sched: directed scenarios with a scoreboard of expected events for hit_sched.
// Latency: events are checked on the negedge they first appear; expected gaps are 2 cycles.
// Backpressure: ev_rdy is toggled per scenario to exercise hold, drops and saturation.
module tb_hit_sched;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] id;
      logic        ts_chk;
      logic [31:0] ts;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic [3:0]  hit_done;
   logic [63:0] hit_id;
   logic [3:0]  cfg_ch_en;
   logic        cfg_ts_clr;
   logic        ev_vld;
   logic        ev_rdy;
   logic [1:0]  ev_ch;
   logic [15:0] ev_id;
   logic [31:0] ev_ts;
   logic [3:0]  stu_pend;
   logic [15:0] stu_drop;
   logic [15:0] stu_ev_cnt;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk_sys = ~clk_sys;

   hit_sched #(.NCH(4), .CHW(2)) dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .hit_done   (hit_done),
      .hit_id     (hit_id),
      .cfg_ch_en  (cfg_ch_en),
      .cfg_ts_clr (cfg_ts_clr),
      .ev_vld     (ev_vld),
      .ev_rdy     (ev_rdy),
      .ev_ch      (ev_ch),
      .ev_id      (ev_id),
      .ev_ts      (ev_ts),
      .stu_pend   (stu_pend),
      .stu_drop   (stu_drop),
      .stu_ev_cnt (stu_ev_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input int ch, input logic [15:0] id);
      hit_id[16*ch +: 16] = id;
   endtask

   task automatic push(input logic [1:0] ch, input logic [15:0] id,
                       input logic ts_chk, input logic [31:0] ts);
      exp_t e;
      e.ch = ch; e.id = id; e.ts_chk = ts_chk; e.ts = ts;
      sb.push_back(e);
   endtask

   // One-cycle hit_done pulse starting now.
   task automatic pulse(input logic [3:0] mask);
      hit_done = mask;
      @(posedge clk_sys);
      #1 hit_done = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1 rst = 1'b0;
   endtask

   // Wait (bounded) for the next presented event and compare it with the scoreboard head.
   task automatic expect_event(input int lat);
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!ev_vld && n < 20);
      check("ev_vld", {31'd0, ev_vld}, 32'd1);
      if (lat > 0) check("latency", n, lat);
      check("ev_ch", {30'd0, ev_ch}, {30'd0, e.ch});
      check("ev_id", {16'd0, ev_id}, {16'd0, e.id});
`ifdef HIT_SCHED_TS_EN
      if (e.ts_chk) check("ev_ts", ev_ts, e.ts);
`else
      check("ev_ts", ev_ts, 32'h0);
`endif
   endtask

   initial begin
      int seen;
      rst = 1'b1; hit_done = '0; hit_id = '0; cfg_ch_en = 4'hF; cfg_ts_clr = 1'b0; ev_rdy = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk_sys);
      check("rst_vld", {31'd0, ev_vld}, 32'd0);
      check("rst_ch", {30'd0, ev_ch}, 32'd0);
      check("rst_id", {16'd0, ev_id}, 32'd0);
      check("rst_ts", ev_ts, 32'd0);
      check("rst_pend", {28'd0, stu_pend}, 32'd0);
      check("rst_drop", {16'd0, stu_drop}, 32'd0);
      check("rst_cnt", {16'd0, stu_ev_cnt}, 32'd0);

      // 1: single event on ch2
      set_id(2, 16'h0005); push(2'd2, 16'h0005, 1'b0, 32'd0);
      pulse(4'b0100);
      expect_event(2);
      @(negedge clk_sys);
      check("t1_cnt", {16'd0, stu_ev_cnt}, 32'd1);
      check("t1_pend", {28'd0, stu_pend}, 32'd0);
      check("t1_vld_low", {31'd0, ev_vld}, 32'd0);

      // 2: round robin from rr_ptr=0, then wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_id(i, 16'(10 + i));
         push(2'(i), 16'(10 + i), 1'b0, 32'd0);
      end
      pulse(4'hF);
      for (int i = 0; i < 4; i++) expect_event(2);
      @(negedge clk_sys);
      check("t2_cnt4", {16'd0, stu_ev_cnt}, 32'd4);
      set_id(0, 16'h0020); set_id(3, 16'h0023);
      push(2'd0, 16'h0020, 1'b0, 32'd0);
      push(2'd3, 16'h0023, 1'b0, 32'd0);
      pulse(4'b1001);
      expect_event(2);
      expect_event(2);
      @(negedge clk_sys);
      check("t2_cnt6", {16'd0, stu_ev_cnt}, 32'd6);

      // 3: drop and saturation while the output is stalled
      ev_rdy = 1'b0;
      set_id(0, 16'h0040); push(2'd0, 16'h0040, 1'b0, 32'd0);
      pulse(4'b0001);
      expect_event(2);
      set_id(1, 16'h0007);
      pulse(4'b0010);
      set_id(1, 16'h0008);
      pulse(4'b0010);
      @(negedge clk_sys);
      check("t3_drop1", {16'd0, stu_drop}, 32'd1);
      check("t3_held_id", {16'd0, ev_id}, 32'h40);
      check("t3_pend", {28'd0, stu_pend}, 32'h2);
      hit_done = 4'b0010;
      repeat (65533) @(posedge clk_sys);
      #1 hit_done = '0;
      @(negedge clk_sys);
      check("t3_drop_fffe", {16'd0, stu_drop}, 32'hFFFE);
      pulse(4'b0010);
      @(negedge clk_sys);
      check("t3_drop_ffff", {16'd0, stu_drop}, 32'hFFFF);
      hit_done = 4'b0010;
      repeat (5) @(posedge clk_sys);
      #1 hit_done = '0;
      @(negedge clk_sys);
      check("t3_drop_sat", {16'd0, stu_drop}, 32'hFFFF);
      check("t3_still_vld", {31'd0, ev_vld}, 32'd1);
      check("t3_still_ch", {30'd0, ev_ch}, 32'd0);
      ev_rdy = 1'b1;
      push(2'd1, 16'h0007, 1'b0, 32'd0);
      expect_event(-1);
      @(negedge clk_sys);
      check("t3_cnt8", {16'd0, stu_ev_cnt}, 32'd8);

      // 4: capture coincident with the load of the same channel
      do_reset();
      set_id(0, 16'h0030); push(2'd0, 16'h0030, 1'b0, 32'd0);
      pulse(4'b0001);
      set_id(0, 16'h0031); push(2'd0, 16'h0031, 1'b0, 32'd0);
      pulse(4'b0001);
      expect_event(-1);
      check("t4_pend_kept", {28'd0, stu_pend}, 32'h1);
      check("t4_drop0", {16'd0, stu_drop}, 32'd0);
      expect_event(2);
      check("t4_drop0b", {16'd0, stu_drop}, 32'd0);
      check("t4_pend_clr", {28'd0, stu_pend}, 32'd0);

      // 5: disabled channel ignored; reset mid-present
      cfg_ch_en = 4'b0111;
      set_id(3, 16'h0055);
      pulse(4'b1000);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_sys);
         if (ev_vld) seen++;
      end
      check("t5_no_event", seen, 0);
      check("t5_no_pend", {28'd0, stu_pend}, 32'd0);
      cfg_ch_en = 4'hF;
      ev_rdy = 1'b0;
      set_id(1, 16'h0050); push(2'd1, 16'h0050, 1'b0, 32'd0);
      pulse(4'b0010);
      expect_event(2);
      set_id(2, 16'h0060);
      pulse(4'b0100);
      pulse(4'b0100);
      @(negedge clk_sys);
      check("t5_drop1", {16'd0, stu_drop}, 32'd1);
      check("t5_cnt2", {16'd0, stu_ev_cnt}, 32'd2);
      rst = 1'b1;
      @(negedge clk_sys);
      check("t5_rst_vld", {31'd0, ev_vld}, 32'd0);
      check("t5_rst_drop", {16'd0, stu_drop}, 32'd0);
      check("t5_rst_cnt", {16'd0, stu_ev_cnt}, 32'd0);
      check("t5_rst_pend", {28'd0, stu_pend}, 32'd0);
      rst = 1'b0;
      ev_rdy = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_sys);
         if (ev_vld) seen++;
      end
      check("t5_lost", seen, 0);

      // 6: timestamp relative to a counter clear
      @(posedge clk_sys);
      #1 cfg_ts_clr = 1'b1;
      @(posedge clk_sys);
      #1 cfg_ts_clr = 1'b0;
      repeat (9) @(posedge clk_sys);
      #1;
      set_id(2, 16'h0066); push(2'd2, 16'h0066, 1'b1, 32'd9);
      pulse(4'b0100);
      expect_event(2);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
